pc_fetch_ctrl: RTL

Fetch sequencer that owns the program counter and drives the instruction-memory request port. It issues one fetch at a time and hands each fetched instruction and its PC to the decode stage over a valid/ready handshake. It applies branch/jump redirects and trap entries, and discards in-flight fetches that a redirect has made stale. It sits between the instruction memory and the IF/ID boundary of the core.

---
 rtl/pc_pkg.sv | 12 +
 rtl/pc_target_sel.sv | 21 ++
 rtl/pc_fetch_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch sequencer.
package pc_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      HOLD    = 2'd2,
      DISCARD = 2'd3
   } fetch_state_t;
endpackage

// File: rtl/pc_target_sel.sv
// Combinational redirect target pick: trap beats branch, word-aligned result, misalign flag.
module pc_target_sel
   import pc_pkg::*;
(
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_vec,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            tgt_vld,
   output logic [XLEN-1:0] tgt_pc,
   output logic            tgt_misalign
);
   logic [XLEN-1:0] sel;

   always_comb begin
      sel          = trap_valid ? trap_vec : redirect_pc;
      tgt_vld      = trap_valid | redirect_valid;
      tgt_pc       = sel & ALIGN_MASK;
      tgt_misalign = tgt_vld && (sel[1:0] != 2'b00);
   end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC owner and single-outstanding imem fetch sequencer; ack to if_valid is 1 cycle.
// Decode backpressure holds the fetched word; redirects cancel held or in-flight fetches.
module pc_fetch_ctrl
   import pc_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0] INSTR_BYTES  = 32'd4
)(
   input  logic            clk,
   input  logic            reset_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            if_valid,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   input  logic            if_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_vec,
   output logic [XLEN-1:0] pc,
   output logic            misalign_err
);
   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pend_pc_q, pend_pc_d;
   logic [XLEN-1:0] if_instr_q, if_instr_d;
   logic [XLEN-1:0] if_pc_q, if_pc_d;
   logic            misalign_q, misalign_d;

   logic            tgt_vld;
   logic [XLEN-1:0] tgt_pc;
   logic            tgt_misalign;

   pc_target_sel u_tgt_sel (
      .trap_valid     (trap_valid),
      .trap_vec       (trap_vec),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .tgt_vld        (tgt_vld),
      .tgt_pc         (tgt_pc),
      .tgt_misalign   (tgt_misalign)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_pc_d  = pend_pc_q;
      if_instr_d = if_instr_q;
      if_pc_d    = if_pc_q;
      misalign_d = tgt_misalign;

      case (state_q)
         IDLE: begin
            state_d = REQ;
            if (tgt_vld) pc_d = tgt_pc;
         end
         REQ: begin
            if (imem_ack) begin
               if (tgt_vld) begin
                  pc_d = tgt_pc;
               end else begin
                  if_instr_d = imem_rdata;
                  if_pc_d    = pc_q;
                  pc_d       = pc_q + INSTR_BYTES;
                  state_d    = HOLD;
               end
            end else if (tgt_vld) begin
               // Address must stay put until the memory acks, so park the target.
               pend_pc_d = tgt_pc;
               state_d   = DISCARD;
            end
         end
         HOLD: begin
            if (tgt_vld) begin
               pc_d    = tgt_pc;
               state_d = REQ;
            end else if (if_ready) begin
               state_d = REQ;
            end
         end
         DISCARD: begin
            if (imem_ack) begin
               pc_d    = tgt_vld ? tgt_pc : pend_pc_q;
               state_d = REQ;
            end else if (tgt_vld) begin
               pend_pc_d = tgt_pc;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         pc_q       <= RESET_VECTOR;
         pend_pc_q  <= RESET_VECTOR;
         if_instr_q <= '0;
         if_pc_q    <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_pc_q  <= pend_pc_d;
         if_instr_q <= if_instr_d;
         if_pc_q    <= if_pc_d;
         misalign_q <= misalign_d;
      end
   end

   assign imem_req     = (state_q == REQ) || (state_q == DISCARD);
   assign imem_addr    = pc_q;
   assign pc           = pc_q;
   assign if_valid     = (state_q == HOLD);
   assign if_instr     = if_instr_q;
   assign if_pc        = if_pc_q;
   assign misalign_err = misalign_q;
endmodule
